// File: rtl/wavefront_load_fsm.sv
// wavefront_load_fsm: skewed valid-wavefront loader for the systolic MAC array.
// A start launches len beats into column 0. Each beat then shifts one column
// per cycle, so column k is valid for len cycles, starting k cycles after
// column 0. An abort drops all in-flight beats. A one-cycle done pulse marks
// the end of every run, whether it completed, was aborted, or had len==0.
module wavefront_load_fsm #(
  parameter int N_COLS = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic [N_COLS-1:0] valid_ctrl,
  output logic              busy,
  output logic              done
);

  // One-hot state encoding.
  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_RUN  = 3'b010;
  localparam logic [2:0] S_DONE = 3'b100;

  logic [2:0]        state_reg, state_next;
  logic [LEN_W-1:0]  len_q, len_next;
  logic [LEN_W-1:0]  issued, issued_next;
  logic [N_COLS-1:0] valid_reg, valid_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic              feed;
  logic [N_COLS-1:0] shifted;

  // Column 0 keeps injecting beats until len_q beats have gone in.
  assign feed = (issued < len_q);

  // The wavefront advances one column per cycle. A new beat enters at column 0.
  // With N_COLS == 1, this reduces to shifted = feed.
  genvar gi;
  generate
    for (gi = 0; gi < N_COLS; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign shifted[gi] = feed;
      end else begin : g_tail
        assign shifted[gi] = valid_reg[gi-1];
      end
    end
  endgenerate

  // Next-state and next-output logic. All outputs are computed here and then registered.
  always_comb begin
    state_next  = state_reg;
    len_next    = len_q;
    issued_next = issued;
    valid_next  = '0;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_next    = S_RUN;
            len_next      = len;
            issued_next   = LEN_W'(1);
            valid_next[0] = 1'b1;
            busy_next     = 1'b1;
          end else begin
            // An empty burst still reports completion, but sets no valid bits.
            state_next = S_DONE;
            done_next  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort || (shifted == '0)) begin
          // An abort drops in-flight beats. A drained array finishes the same way.
          state_next = S_DONE;
          done_next  = 1'b1;
        end else begin
          valid_next = shifted;
          busy_next  = 1'b1;
          if (feed) begin
            issued_next = issued + LEN_W'(1);
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        // Recover from a corrupted state register with everything cleared.
        state_next  = S_IDLE;
        len_next    = '0;
        issued_next = '0;
      end
    endcase
  end

  // State and output registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      len_q     <= '0;
      issued    <= '0;
      valid_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_q     <= len_next;
      issued    <= issued_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign valid_ctrl = valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: doc/wavefront_load_fsm.md
# wavefront_load_fsm

Parametrised load sequencer for the systolic MAC array. On a start pulse it drives a skewed valid wavefront across `N_COLS` columns: column k is enabled for `len` consecutive cycles, starting k cycles after column 0. This models data marching one MAC per cycle. It replaces the fixed two-column, single-beat loader. It adds programmable burst length, abort, and a completion pulse, and sits between the array controller and the `valid_in_0` inputs of the MAC array.

## Interface
- `N_COLS`, default 4: number of MAC columns driven; must be >= 1.
- `LEN_W`, default 8: width of the burst-length input; maximum burst is 2^LEN_W-1 beats.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  launch request; sampled only in IDLE.
- `len`  in  LEN_W  beats per column; latched when start is accepted.
- `abort`  in  1  cancel request; sampled only in RUN.
- `valid_ctrl`  out  N_COLS  per-column valid; bit k goes to MAC column k.
- `busy`  out  1  high while a wavefront is in flight (RUN).
- `done`  out  1  single-cycle completion pulse (DONE).

## Operation
- States: IDLE, RUN, DONE. Encoding is one-hot. All outputs are registered.
- Internal registers:
  - `len_q` (LEN_W), the latched length.
  - `issued` (LEN_W), the count of beats injected at column 0.
- **IDLE:**
  - start=1 and len!=0 → RUN. Latch len_q=len. valid_ctrl=1 (bit 0 only). issued=1. busy=1.
  - start=1 and len==0 → DONE with no valid beats.
  - start=0 → stay in IDLE, all outputs 0.
- **RUN, each edge:**
  - valid_ctrl <= {valid_ctrl[N_COLS-2:0], feed}, where feed = (issued < len_q).
  - issued increments when feed=1 and saturates at len_q.
  - N_COLS=1: valid_ctrl <= feed.
  - When the next valid_ctrl would be all-zero → DONE.
- **RUN with abort=1:** next edge forces valid_ctrl=0 → DONE. In-flight beats are dropped, not drained.
- **DONE:** lasts exactly one cycle. done=1, busy=0, valid_ctrl=0. Then → IDLE. start and abort are ignored here.
- start while busy or in DONE: ignored, not queued. Changes on len while busy are ignored.
- abort in IDLE or DONE: ignored. start and abort asserted together in IDLE: start is accepted.
- rst overrides everything on the next edge: state IDLE, valid_ctrl=0, busy=0, done=0, counters 0. This includes reset mid-RUN.
- Illegal state encoding → IDLE with outputs cleared.

## Timing
- Reset values: valid_ctrl=0, busy=0, done=0.
- Latency: start sampled at edge E0 drives valid_ctrl[0] in the cycle after E0.
- Column k is high from edge Ek through E(k+len-1) inclusive, i.e. exactly len cycles.
- busy is high for len+N_COLS-1 cycles.
- done is high in the cycle after edge E(len+N_COLS-1).
- Earliest next accepted start is 1 cycle after done, i.e. back-to-back start pulses are separated by len+N_COLS+1 cycles.
- Adjacent columns overlap: at most min(len,N_COLS) bits are set in valid_ctrl at once.
- Abort sampled at edge Ea: valid_ctrl=0 and done=1 in the cycle after Ea.

## Test plan
- **Nominal run,** N_COLS=4, len=3, start at E0. valid_ctrl after E0..E6 must be 0001, 0011, 0111, 1110, 1100, 1000, 0000. done=1 only after E6. busy=1 after E0..E5.
- **Single beat,** N_COLS=4, len=1. valid_ctrl must be 0001, 0010, 0100, 1000, then 0000 with done=1. This is the one-hot walk.
- **len=0 start.** No valid bits ever set. done=1 in the cycle after the start edge. busy stays 0.
- **Abort,** N_COLS=4, len=5, abort sampled at E2. The cycle after must show valid_ctrl=0000, done=1. The following cycle is IDLE. A new start is then accepted normally.
- **Ignored inputs.**
  - start pulses and len changes during RUN and DONE: the wavefront is unchanged and there is no second done.
  - start+abort together in IDLE: the run starts.
- **Reset mid-RUN,** len=200 with rst at E3. The cycle after must show valid_ctrl=0, busy=0, done=0. Also repeat the nominal run with N_COLS=1 and N_COLS=8, len=255, checking the 255-cycle column high time.
